// File: rtl/add_subt_slice_unit.sv
// Slice-serial two's-complement add/subtract responder for the CORDIC datapath.
// One DIGIT-wide slice per cycle through a carry register, optional saturation.
module add_subt_slice_unit #(
  parameter int W        = 32,
  parameter int DIGIT    = 8,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         op,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         ready_add_subt,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         busy
);

  localparam int NSLICE = W / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  generate
    if (W % DIGIT != 0) begin : g_bad_digit
      $error("W must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    SAT,
    DONE,
    WAITLOW
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   slice_sum;
  logic             ovf;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_r[k*DIGIT +: DIGIT];
        b_sl = b_r[k*DIGIT +: DIGIT];
      end
    end
  end

  assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl}
                   + {{DIGIT{1'b0}}, carry};

  // b_r already holds ~B for subtraction, so one rule covers both ops
  assign ovf = (a_r[W-1] == b_r[W-1])
            && (result[W-1] != a_r[W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ready_add_subt <= 1'b0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
      result         <= '0;
      carry          <= 1'b0;
      cnt            <= '0;
      a_r            <= '0;
      b_r            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (beg_add_subt) begin
            a_r      <= data_a;
            b_r      <= op ? ~data_b : data_b;
            carry    <= op;
            cnt      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
              result[k*DIGIT +: DIGIT] <= slice_sum[DIGIT-1:0];
            end
          end
          carry <= slice_sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= SAT;
          end
        end
        SAT: begin
          overflow <= ovf;
          if (SATURATE != 0 && ovf) begin
            result <= a_r[W-1] ? SAT_MIN : SAT_MAX;
          end
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          // ready is raised first so a dropped beg still sees one pulse
          if (!ready_add_subt) begin
            ready_add_subt <= 1'b1;
          end else if (!beg_add_subt) begin
            ready_add_subt <= 1'b0;
            state          <= IDLE;
          end else if (ack_add_subt) begin
            ready_add_subt <= 1'b0;
            state          <= WAITLOW;
          end
        end
        WAITLOW: begin
          if (!beg_add_subt) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_subt_slice_unit.sv
// Randomised and directed bench for add_subt_slice_unit.
// Saturating and wrapping instances share stimulus, checked against a model.
module tb_add_subt_slice_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        beg_add_subt;
  logic        ack_add_subt;
  logic        op;
  logic [31:0] data_a;
  logic [31:0] data_b;

  logic        ready_s, ready_w;
  logic [31:0] result_s, result_w;
  logic        ovf_s, ovf_w;
  logic        busy_s, busy_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  add_subt_slice_unit #(.W(32), .DIGIT(8), .SATURATE(1)) dut (
    .clk(clk), .reset(reset),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
    .op(op), .data_a(data_a), .data_b(data_b),
    .ready_add_subt(ready_s), .result(result_s),
    .overflow(ovf_s), .busy(busy_s)
  );

  add_subt_slice_unit #(.W(32), .DIGIT(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
    .op(op), .data_a(data_a), .data_b(data_b),
    .ready_add_subt(ready_w), .result(result_w),
    .overflow(ovf_w), .busy(busy_w)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {overflow, result} from true signed arithmetic
  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic o,
                                        input bit sat);
    longint r;
    logic [31:0] res;
    logic v;
    r = o ? longint'($signed(a)) - longint'($signed(b))
          : longint'($signed(a)) + longint'($signed(b));
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    res = r[31:0];
    if (sat && v) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {v, res};
  endfunction

  // accept a request, return with ready high (beg still high)
  task automatic start_and_wait(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic o);
    int lat;
    int bcnt;
    logic [32:0] es, ew;
    @(negedge clk);
    beg_add_subt = 1'b1;
    data_a = a;
    data_b = b;
    op = o;
    @(posedge clk);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      data_a = $urandom;
      data_b = $urandom;
      op = 1'($urandom_range(0, 1));
      if (busy_s) bcnt++;
      if (ready_s) begin
        lat = i;
        break;
      end
    end
    es = model(a, b, o, 1'b1);
    ew = model(a, b, o, 1'b0);
    check("latency", 64'(lat), 64'd6);
    check("busy_cycles", 64'(bcnt), 64'd5);
    check("ready_wrap", 64'(ready_w), 64'd1);
    check("result_sat", 64'(result_s), 64'(es[31:0]));
    check("ovf_sat", 64'(ovf_s), 64'(es[32]));
    check("result_wrap", 64'(result_w), 64'(ew[31:0]));
    check("ovf_wrap", 64'(ovf_w), 64'(ew[32]));
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic o);
    logic [32:0] es;
    start_and_wait(a, b, o);
    beg_add_subt = 1'b0;
    @(negedge clk);
    es = model(a, b, o, 1'b1);
    check("ready_release", 64'(ready_s), 64'd0);
    check("result_hold", 64'(result_s), 64'(es[31:0]));
  endtask

  initial begin
    int rcnt;
    logic [31:0] ra, rb;
    logic ro;
    reset = 1'b1;
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    op = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_s), 64'd0);
    check("rst_busy", 64'(busy_s), 64'd0);
    check("rst_result", 64'(result_s), 64'd0);
    check("rst_ovf", 64'(ovf_s), 64'd0);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op(32'd5, 32'd7, 1'b1);
    run_op(32'h1234_5678, 32'h0000_5678, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 1'($urandom_range(0, 1));
      if (n % 4 == 0) ra = {ra[31], {31{~ra[31]}}};
      run_op(ra, rb, ro);
    end

    // ack with beg held: ready drops, no restart while beg high
    start_and_wait(32'd100, 32'd1, 1'b0);
    ack_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
    check("ack_ready_low", 64'(ready_s), 64'd0);
    rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_s || busy_s) rcnt++;
    end
    check("held_beg_idle", 64'(rcnt), 64'd0);
    check("held_beg_result", 64'(result_s), 64'd101);
    beg_add_subt = 1'b0;
    run_op(32'd3, 32'd4, 1'b0);
    check("readd_result", 64'(result_s), 64'd7);

    // beg dropped during CALC: exactly one ready cycle
    @(negedge clk);
    beg_add_subt = 1'b1;
    data_a = 32'd20;
    data_b = 32'd22;
    op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    beg_add_subt = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ready_s) rcnt++;
    end
    check("drop_ready_cycles", 64'(rcnt), 64'd1);
    check("drop_result", 64'(result_s), 64'd42);

    // reset during second CALC cycle
    @(negedge clk);
    beg_add_subt = 1'b1;
    data_a = 32'hDEAD_BEEF;
    data_b = 32'h0101_0101;
    op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    beg_add_subt = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_s), 64'd0);
    check("midrst_busy", 64'(busy_s), 64'd0);
    check("midrst_result", 64'(result_s), 64'd0);
    reset = 1'b0;
    run_op(32'd10, 32'd3, 1'b1);
    check("post_rst_result", 64'(result_s), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
